hyperbus_read_ctrl: RTL and testbench
=====================================

// Module: hyperbus_read_ctrl
// PURPOSE
// Sequences one HyperBus read burst on the clk0 side of the RWDS-clocked capture path.
// Gates the RWDS read clock and DDR capture enable, then pulls 16-bit words from the read CDC FIFO.
// Forwards exactly req_len_i words through a registered output stage and discards any surplus words.
// Flags a timeout if RWDS stops delivering data.
// PARAMETERS
// LEN_W        16    width of burst length / word counters
// TIMEOUT_CYC  1024  clk0 cycles with no FIFO word in READ before abort (>=2)
// FLUSH_CYC    8     clk0 cycles spent draining stray FIFO words after clock gate closes (>=1)
// PORTS
// clk0          in   1      system clock; the only clock of this block
// rst_ni        in   1      asynchronous active-low reset
// req_valid_i   in   1      read burst request
// req_len_i     in   LEN_W  burst length in 16-bit words
// req_ready_o   out  1      request accepted when req_valid_i && req_ready_o
// abort_i       in   1      abandon the current burst
// read_clk_en_o out  1      RWDS read-clock gate enable
// en_ddr_in_o   out  1      DDR input capture enable
// fifo_valid_i  in   1      CDC FIFO word available
// fifo_data_i   in   16     CDC FIFO word
// fifo_ready_o  out  1      pop CDC FIFO
// rx_valid_o    out  1      output word valid
// rx_data_o     out  16     output word
// rx_ready_i    in   1      downstream accepts the output word
// busy_o        out  1      state != IDLE
// done_o        out  1      1-cycle pulse at burst end (normal, timeout or abort)
// err_o         out  1      1-cycle pulse, coincident with done_o, on timeout
// rcvd_cnt_o    out  LEN_W  words forwarded in the current/last burst
// BEHAVIOUR
// Reset values:
// - state=IDLE; req_ready_o=1; read_clk_en_o=en_ddr_in_o=0.
// - rx_valid_o=0, rx_data_o=0; done_o=err_o=0; rcvd_cnt_o=0.
// - All internal counters cleared.
// IDLE:
// - req_ready_o=1, all other controls 0.
// - On request handshake with len!=0: load rem=len, clear rcvd_cnt_o and timeout counter, go READ.
// - On request handshake with len==0: next cycle done_o=1; no enables raised; stay IDLE.
// READ:
// - read_clk_en_o=en_ddr_in_o=1 (registered outputs, high starting the cycle after accept).
// - fifo_ready_o = rem!=0 && (!rx_valid_o || rx_ready_i).
// - Each FIFO pop loads rx_data_o, sets rx_valid_o, decrements rem, increments rcvd_cnt_o, clears the timeout counter.
// - rx_valid_o clears on rx_ready_i when no new pop occurs in the same cycle.
// - Forwarding latency is 1 cycle. A simultaneous pop and rx handshake keeps rx_valid_o=1.
// - Timeout counter increments on every cycle without a pop. Reaching TIMEOUT_CYC-1 latches a timeout flag and moves to FLUSH.
// - Last pop (rem 1->0), timeout, or abort_i: go FLUSH. Enables drop to 0 the next cycle.
// - abort_i has priority over a pop in the same cycle; that word is discarded.
// FLUSH:
// - Enables are 0. The flush counter runs FLUSH_CYC cycles.
// - fifo_ready_o=1 unconditionally; popped words are dropped and never reach rx_*.
// - A pending rx_valid_o word is still delivered, including after an abort.
// - Go DONE when the flush counter expires and rx_valid_o==0.
// DONE:
// - done_o=1 for one cycle; err_o=1 if the timeout flag is set. Return to IDLE.
// Other rules:
// - abort_i in IDLE or DONE is ignored.
// - rem and rcvd_cnt_o are LEN_W-bit; maximum burst is 2^LEN_W-1 words. No wrap can occur because rem stops at 0.
// - Async reset mid-burst returns to reset values immediately. read_clk_en_o drops asynchronously.
// - Simulation only: assertion fires if fifo_valid_i && !fifo_ready_o persists >4 cycles in READ (risk of CDC overflow).
// TESTING
// 1. len=4, FIFO words 0x1111..0x4444 back-to-back, rx_ready_i=1.
//    -> rx words in order 1 cycle after each pop; rcvd_cnt_o=4; enables high 4+ cycles; done_o pulse, err_o=0.
// 2. len=3, rx_ready_i toggling 1/0.
//    -> fifo_ready_o low while output is stalled; no word lost or duplicated; done_o only after the last rx handshake.
// 3. len=8, FIFO delivers 2 words then stops, TIMEOUT_CYC=16.
//    -> enables drop 16 cycles after the last pop; done_o and err_o pulse together; rcvd_cnt_o=2.
// 4. len=2, FIFO presents 4 words.
//    -> only 0xA/0xB forwarded; words 3-4 popped in FLUSH and dropped; done_o=1, err_o=0.
// 5. len=0 request -> no enable asserted; done_o pulse next cycle. abort_i after the 1st word of len=5 -> 1 word out, done_o, err_o=0.
// 6. rst_ni low mid-READ (len=6, 3 words in) -> all outputs at reset values immediately; new len=1 request completes normally.

Source files
------------

// File: rtl/hyperbus_read_ctrl.sv
// HyperBus read-burst sequencer on the clk0 side: gates the RWDS capture path,
// drains the read CDC FIFO and forwards exactly the requested number of words.
//
// state | meaning
// IDLE  | waiting for a request; zero-length requests complete here
// READ  | capture enabled, popping FIFO words into the output stage
// FLUSH | capture gated off, dropping stray FIFO words, draining the output stage
// DONE  | one-cycle completion pulse (err_o alongside on timeout)
module hyperbus_read_ctrl #(
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 1024,
    parameter int FLUSH_CYC   = 8
) (
    input  logic             clk0,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    input  logic [LEN_W-1:0] req_len_i,
    output logic             req_ready_o,
    input  logic             abort_i,
    output logic             read_clk_en_o,
    output logic             en_ddr_in_o,
    input  logic             fifo_valid_i,
    input  logic [15:0]      fifo_data_i,
    output logic             fifo_ready_o,
    output logic             rx_valid_o,
    output logic [15:0]      rx_data_o,
    input  logic             rx_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] rcvd_cnt_o
);

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_e;

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int FW = $clog2(FLUSH_CYC + 1);
    // Down-counters: terminal count 0 means TIMEOUT_CYC-1 idle cycles / FLUSH_CYC cycles elapsed.
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYC - 2);
    localparam logic [FW-1:0] FL_LOAD = FW'(FLUSH_CYC - 1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] rcvd_q, rcvd_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic             to_flag_q, to_flag_d;
    logic             rx_valid_q, rx_valid_d;
    logic [15:0]      rx_data_q, rx_data_d;
    logic             read_clk_en_q, en_ddr_in_q, en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             pop;

    assign fifo_ready_o = ((state_q == READ) && (rem_q != '0) && (!rx_valid_q || rx_ready_i))
                        || (state_q == FLUSH);
    assign pop          = fifo_valid_i && fifo_ready_o;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        rcvd_d     = rcvd_q;
        tcnt_d     = tcnt_q;
        fcnt_d     = fcnt_q;
        to_flag_d  = to_flag_q;
        rx_valid_d = rx_valid_q && !rx_ready_i;
        rx_data_d  = rx_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_len_i != '0) begin
                        rem_d     = req_len_i;
                        rcvd_d    = '0;
                        tcnt_d    = TO_LOAD;
                        to_flag_d = 1'b0;
                        state_d   = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                // Abort wins over a same-cycle pop; that word is dropped.
                if (abort_i) begin
                    state_d = FLUSH;
                    fcnt_d  = FL_LOAD;
                end else if (pop) begin
                    rx_data_d  = fifo_data_i;
                    rx_valid_d = 1'b1;
                    rem_d      = rem_q - LEN_W'(1);
                    rcvd_d     = rcvd_q + LEN_W'(1);
                    tcnt_d     = TO_LOAD;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = FLUSH;
                        fcnt_d  = FL_LOAD;
                    end
                end else if (tcnt_q == '0) begin
                    to_flag_d = 1'b1;
                    state_d   = FLUSH;
                    fcnt_d    = FL_LOAD;
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end
            FLUSH: begin
                if (fcnt_q != '0) begin
                    fcnt_d = fcnt_q - FW'(1);
                end else if (!rx_valid_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = to_flag_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        en_d = (state_d == READ);
    end

    always_ff @(posedge clk0 or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            rcvd_q        <= '0;
            tcnt_q        <= '0;
            fcnt_q        <= '0;
            to_flag_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            rx_data_q     <= '0;
            read_clk_en_q <= 1'b0;
            en_ddr_in_q   <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            rcvd_q        <= rcvd_d;
            tcnt_q        <= tcnt_d;
            fcnt_q        <= fcnt_d;
            to_flag_q     <= to_flag_d;
            rx_valid_q    <= rx_valid_d;
            rx_data_q     <= rx_data_d;
            read_clk_en_q <= en_d;
            en_ddr_in_q   <= en_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign read_clk_en_o = read_clk_en_q;
    assign en_ddr_in_o   = en_ddr_in_q;
    assign rx_valid_o    = rx_valid_q;
    assign rx_data_o     = rx_data_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign rcvd_cnt_o    = rcvd_q;

`ifndef SYNTHESIS
    // A FIFO word left waiting in READ for more than 4 cycles risks overflowing the CDC FIFO.
    logic [2:0] ovf_cnt_q;
    logic       ovf_risk;
    assign ovf_risk = (state_q == READ) && fifo_valid_i && !fifo_ready_o;

    always_ff @(posedge clk0 or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_cnt_q <= '0;
        end else if (!ovf_risk) begin
            ovf_cnt_q <= '0;
        end else if (ovf_cnt_q != 3'd7) begin
            ovf_cnt_q <= ovf_cnt_q + 3'd1;
        end
    end

    always @(posedge clk0) begin
        if (rst_ni) begin
            assert (!(ovf_risk && (ovf_cnt_q >= 3'd4)));
        end
    end
`endif

endmodule

// File: tb/tb_hyperbus_read_ctrl.sv
// Bench for hyperbus_read_ctrl: burst table, timing sequences, reset and
// randomized bursts checked against a word-stream reference.
module tb_hyperbus_read_ctrl;

    localparam int LEN_W       = 16;
    localparam int TIMEOUT_CYC = 16;
    localparam int FLUSH_CYC   = 8;

    logic             clk0 = 1'b0;
    logic             rst_ni;
    logic             req_valid_i;
    logic [LEN_W-1:0] req_len_i;
    logic             req_ready_o;
    logic             abort_i;
    logic             read_clk_en_o;
    logic             en_ddr_in_o;
    logic             fifo_valid_i;
    logic [15:0]      fifo_data_i;
    logic             fifo_ready_o;
    logic             rx_valid_o;
    logic [15:0]      rx_data_o;
    logic             rx_ready_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [LEN_W-1:0] rcvd_cnt_o;

    always #5 clk0 = ~clk0;

    hyperbus_read_ctrl #(
        .LEN_W      (LEN_W),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .FLUSH_CYC  (FLUSH_CYC)
    ) dut (
        .clk0         (clk0),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_len_i    (req_len_i),
        .req_ready_o  (req_ready_o),
        .abort_i      (abort_i),
        .read_clk_en_o(read_clk_en_o),
        .en_ddr_in_o  (en_ddr_in_o),
        .fifo_valid_i (fifo_valid_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_ready_o (fifo_ready_o),
        .rx_valid_o   (rx_valid_o),
        .rx_data_o    (rx_data_o),
        .rx_ready_i   (rx_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .rcvd_cnt_o   (rcvd_cnt_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Words the FIFO will offer for the next burst, and what the burst produced.
    logic [15:0] stim_q[$];
    int          g_words[$];
    int          g_done_cnt, g_err, g_rcvd, g_busy, g_en_cycles;
    int          g_last_pop, g_en_fall, g_done_cyc, g_pops;
    bit          g_reset_hit;

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_ready"}, req_ready_o, 1);
        chk({tag, "_clk_en"}, read_clk_en_o, 0);
        chk({tag, "_ddr_en"}, en_ddr_in_o, 0);
        chk({tag, "_rx_valid"}, rx_valid_o, 0);
        chk({tag, "_rx_data"}, rx_data_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_rcvd"}, rcvd_cnt_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
    endtask

    // Runs one burst from IDLE; entered and left 1 time unit after a rising edge.
    task automatic do_burst(input int len, input int rdy_mode, input int vld_mode,
                            input int abort_at, input int rst_after);
        logic [15:0] sup[$];
        logic [15:0] fwd_word, d;
        int cyc, lowrun, gaprun;
        bit aborted, was_en, fwd_pending, seen_done, pop, hs, ab, en_now, vld;
        sup = stim_q;
        cyc = 0; lowrun = 0; gaprun = 0;
        aborted = 0; was_en = 0; fwd_pending = 0; seen_done = 0; fwd_word = '0;
        g_words.delete();
        g_done_cnt = 0; g_err = 0; g_rcvd = 0; g_busy = 0; g_en_cycles = 0;
        g_last_pop = -1; g_en_fall = -1; g_done_cyc = -1; g_pops = 0; g_reset_hit = 0;
        req_valid_i = 1'b1;
        req_len_i   = LEN_W'(len);
        for (int k = 0; k < 400; k++) begin
            if (rst_after >= 0 && g_pops == rst_after) begin
                chk("rcvd_before_rst", rcvd_cnt_o, rst_after);
                rst_ni = 1'b0;
                #1;
                check_reset_values("mid_rst");
                g_reset_hit = 1;
                break;
            end
            if (k > 0) req_valid_i = 1'b0;
            vld = (sup.size() > 0);
            if (vld && vld_mode == 1) begin
                if (gaprun == 0 && $urandom_range(0, 3) == 0) begin
                    vld = 0; gaprun = 1;
                end else begin
                    gaprun = 0;
                end
            end
            fifo_valid_i = vld;
            fifo_data_i  = (sup.size() > 0) ? sup[0] : 16'h0000;
            case (rdy_mode)
                0: rx_ready_i = 1'b1;
                1: rx_ready_i = (cyc % 2 == 0);
                default: begin
                    rx_ready_i = (lowrun >= 2) ? 1'b1 : ($urandom_range(0, 1) == 1);
                    lowrun     = rx_ready_i ? 0 : lowrun + 1;
                end
            endcase
            abort_i = (abort_at >= 0 && !aborted && g_pops == abort_at && read_clk_en_o);
            #2;
            pop    = fifo_valid_i && fifo_ready_o;
            hs     = rx_valid_o && rx_ready_i;
            d      = rx_data_o;
            ab     = abort_i;
            en_now = read_clk_en_o;
            chk("en_ddr_match", en_ddr_in_o, read_clk_en_o);
            if (en_now && rx_valid_o && !rx_ready_i) chk("stall_no_pop", fifo_ready_o, 0);
            if (busy_o && !en_now && !done_o) chk("flush_pop", fifo_ready_o, 1);
            if (!busy_o) chk("idle_no_pop", fifo_ready_o, 0);
            @(posedge clk0);
            #1;
            cyc++;
            if (ab) aborted = 1;
            fwd_pending = 0;
            if (pop) begin
                if (en_now && !ab) begin
                    fwd_pending = 1;
                    fwd_word    = sup[0];
                    g_last_pop  = cyc - 1;
                end
                void'(sup.pop_front());
                g_pops++;
            end
            if (hs) g_words.push_back(int'(d));
            if (fwd_pending) begin
                chk("fwd_valid", rx_valid_o, 1);
                chk("fwd_data", rx_data_o, fwd_word);
            end
            if (read_clk_en_o) g_en_cycles++;
            if (was_en && !read_clk_en_o && g_en_fall < 0) g_en_fall = cyc;
            was_en = read_clk_en_o;
            chk("err_only_with_done", int'(err_o & ~done_o), 0);
            if (seen_done && !done_o) break;
            if (done_o) begin
                if (!seen_done) begin
                    g_err      = err_o;
                    g_rcvd     = rcvd_cnt_o;
                    g_busy     = busy_o;
                    g_done_cyc = cyc;
                end
                seen_done = 1;
                g_done_cnt++;
            end
        end
        if (!g_reset_hit) chk("burst_done_seen", seen_done, 1);
        req_valid_i  = 1'b0;
        fifo_valid_i = 1'b0;
        rx_ready_i   = 1'b1;
        abort_i      = 1'b0;
    endtask

    typedef struct {
        int len;
        int nsup;
        int base;
        int step;
        int rdy_mode;
        int vld_mode;
        int abort_at;
        int exp_words;
        int exp_err;
        int exp_en_min;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //           len nsup base     step     rdy vld abort words err en_min
        vecs[0] = '{4, 4, 'h1111, 'h1111, 0, 0, -1, 4, 0, 4};
        vecs[1] = '{3, 3, 'h0100, 'h0001, 1, 0, -1, 3, 0, 3};
        vecs[2] = '{8, 2, 'h5A00, 'h0011, 0, 0, -1, 2, 1, TIMEOUT_CYC};
        vecs[3] = '{2, 4, 'h000A, 'h0001, 0, 0, -1, 2, 0, 2};
        vecs[4] = '{0, 0, 'h0000, 'h0000, 0, 0, -1, 0, 0, 0};
        vecs[5] = '{5, 5, 'hC000, 'h0101, 0, 0, 1, 1, 0, 1};
        vecs[6] = '{1, 1, 'hBEEF, 'h0000, 0, 0, -1, 1, 0, 1};
        vecs[7] = '{6, 8, 'h7000, 'h0123, 2, 1, -1, 6, 0, 6};

        rst_ni       = 1'b1;
        req_valid_i  = 1'b0;
        req_len_i    = '0;
        abort_i      = 1'b0;
        fifo_valid_i = 1'b0;
        fifo_data_i  = '0;
        rx_ready_i   = 1'b1;
        #1 rst_ni = 1'b0;
        #1;
        check_reset_values("reset");
        @(posedge clk0);
        @(posedge clk0);
        #1 rst_ni = 1'b1;

        for (int r = 0; r < 8; r++) begin
            stim_q.delete();
            for (int i = 0; i < vecs[r].nsup; i++)
                stim_q.push_back(16'(vecs[r].base + i * vecs[r].step));
            do_burst(vecs[r].len, vecs[r].rdy_mode, vecs[r].vld_mode, vecs[r].abort_at, -1);
            chk("words_cnt", g_words.size(), vecs[r].exp_words);
            for (int i = 0; i < vecs[r].exp_words && i < g_words.size(); i++)
                chk("word", g_words[i], int'(stim_q[i]));
            chk("done_pulses", g_done_cnt, 1);
            chk("err", g_err, vecs[r].exp_err);
            chk("fifo_drained", g_pops, vecs[r].nsup);
            chk("busy_at_done", g_busy, int'(vecs[r].len != 0));
            if (vecs[r].len == 0) begin
                chk("no_enable", g_en_cycles, 0);
            end else begin
                chk("en_min", int'(g_en_cycles >= vecs[r].exp_en_min), 1);
                chk("rcvd", g_rcvd, vecs[r].exp_words);
            end
        end

        // Normal end: enables drop the cycle after the last pop, flush lasts FLUSH_CYC.
        stim_q.delete();
        for (int i = 0; i < 4; i++) stim_q.push_back(16'((i + 1) * 'h1111));
        do_burst(4, 0, 0, -1, -1);
        chk("norm_en_fall", g_en_fall - g_last_pop, 1);
        chk("norm_flush_len", g_done_cyc - g_en_fall, FLUSH_CYC);
        chk("norm_rcvd", g_rcvd, 4);

        // Timeout: enables drop TIMEOUT_CYC cycles after the last pop.
        stim_q.delete();
        stim_q.push_back(16'h0A0A);
        stim_q.push_back(16'h0B0B);
        do_burst(8, 0, 0, -1, -1);
        chk("to_en_fall", g_en_fall - g_last_pop, TIMEOUT_CYC);
        chk("to_flush_len", g_done_cyc - g_en_fall, FLUSH_CYC);
        chk("to_err", g_err, 1);
        chk("to_rcvd", g_rcvd, 2);

        // abort_i in IDLE does nothing.
        abort_i = 1'b1;
        @(posedge clk0);
        #1;
        abort_i = 1'b0;
        chk("idle_abort_busy", busy_o, 0);
        chk("idle_abort_done", done_o, 0);
        chk("idle_abort_en", read_clk_en_o, 0);

        // Reset mid-READ, then a fresh single-word burst.
        stim_q.delete();
        for (int i = 0; i < 6; i++) stim_q.push_back(16'(16'h3300 + i));
        do_burst(6, 0, 0, -1, 3);
        chk("reset_hit", g_reset_hit, 1);
        @(posedge clk0);
        #1 rst_ni = 1'b1;
        stim_q.delete();
        stim_q.push_back(16'h9C9C);
        do_burst(1, 0, 0, -1, -1);
        chk("post_rst_words", g_words.size(), 1);
        if (g_words.size() > 0) chk("post_rst_word", g_words[0], 'h9C9C);
        chk("post_rst_rcvd", g_rcvd, 1);
        chk("post_rst_err", g_err, 0);

        // Random bursts: output stream must be exactly the first len FIFO words.
        for (int b = 0; b < 30; b++) begin
            int len, extra;
            len   = $urandom_range(1, 12);
            extra = $urandom_range(0, 3);
            stim_q.delete();
            for (int i = 0; i < len + extra; i++) stim_q.push_back(16'($urandom));
            do_burst(len, 2, 1, -1, -1);
            chk("rnd_words_cnt", g_words.size(), len);
            for (int i = 0; i < len && i < g_words.size(); i++)
                chk("rnd_word", g_words[i], int'(stim_q[i]));
            chk("rnd_rcvd", g_rcvd, len);
            chk("rnd_err", g_err, 0);
            chk("rnd_done_pulses", g_done_cnt, 1);
            chk("rnd_drained", g_pops, len + extra);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
